// File: rtl/alu_pkg.sv
// alu_pkg: shared operation codes, ALUOp/funct encodings and FSM state type
package alu_pkg;
    localparam logic [3:0] ALU_AND     = 4'b0000;
    localparam logic [3:0] ALU_OR      = 4'b0001;
    localparam logic [3:0] ALU_ADD     = 4'b0010;
    localparam logic [3:0] ALU_XOR     = 4'b0011;
    localparam logic [3:0] ALU_SRL     = 4'b0100;
    localparam logic [3:0] ALU_SRA     = 4'b0101;
    localparam logic [3:0] ALU_SUB     = 4'b0110;
    localparam logic [3:0] ALU_SLT     = 4'b0111;
    localparam logic [3:0] ALU_SLL     = 4'b1000;
    localparam logic [3:0] ALU_SLTU    = 4'b1001;
    localparam logic [3:0] ALU_ILLEGAL = 4'b1111;
    localparam logic [1:0] ALUOP_LS = 2'b00;
    localparam logic [1:0] ALUOP_BR = 2'b01;
    localparam logic [1:0] ALUOP_R  = 2'b10;
    localparam logic [1:0] ALUOP_I  = 2'b11;
    localparam logic [3:0] F_ADD  = 4'b0000;
    localparam logic [3:0] F_SUB  = 4'b1000;
    localparam logic [3:0] F_SLL  = 4'b0001;
    localparam logic [3:0] F_SLT  = 4'b0010;
    localparam logic [3:0] F_SLTU = 4'b0011;
    localparam logic [3:0] F_XOR  = 4'b0100;
    localparam logic [3:0] F_SRL  = 4'b0101;
    localparam logic [3:0] F_SRA  = 4'b1101;
    localparam logic [3:0] F_OR   = 4'b0110;
    localparam logic [3:0] F_AND  = 4'b0111;
    typedef enum logic {IDLE, SHIFT} state_e;
endpackage

// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response handshake bundle of the EX-stage ALU
interface alu_exec_unit_if #(
    parameter int XLEN = 32,
    parameter int OP_W = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      alu_op;
    logic [3:0]      funct;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            illegal;
    logic [OP_W-1:0] operation;
    modport master (
        output in_valid, alu_op, funct, operand_a, operand_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, operation
    );
    modport slave (
        input  in_valid, alu_op, funct, operand_a, operand_b, out_ready,
        output in_ready, out_valid, result, zero, illegal, operation
    );
endinterface

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational {alu_op, funct} to operation code decoder
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [3:0] funct,
    output logic [3:0] operation
);
    logic [3:0] f;
    logic [3:0] r;
    always_comb begin
        f = (alu_op == ALUOP_I && funct != F_SRA) ? {1'b0, funct[2:0]} : funct;
        case (f)
            F_ADD:   r = ALU_ADD;
            F_SUB:   r = ALU_SUB;
            F_SLL:   r = ALU_SLL;
            F_SLT:   r = ALU_SLT;
            F_SLTU:  r = ALU_SLTU;
            F_XOR:   r = ALU_XOR;
            F_SRL:   r = ALU_SRL;
            F_SRA:   r = ALU_SRA;
            F_OR:    r = ALU_OR;
            F_AND:   r = ALU_AND;
            default: r = ALU_ILLEGAL;
        endcase
        operation = alu_op == ALUOP_LS ? ALU_ADD : alu_op == ALUOP_BR ? ALU_SUB : r;
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with registered result and an iterative SHIFT_STEP-bit shifter
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1,
    parameter int OP_W       = 4
) (
    input logic clk,
    input logic reset_n,
    input logic flush,
    alu_exec_unit_if.slave io
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] STEP = CW'(SHIFT_STEP);
    state_e          state_q, state_d;
    logic [3:0]      dec_op, sh_op;
    logic [XLEN-1:0] alu_res, sh_val, sh_nxt;
    logic [CW-1:0]   amt, sh_rem, step;
    logic            is_shift, acc, ld_now, sh_done;
    alu_op_decode u_dec (.alu_op(io.alu_op), .funct(io.funct), .operation(dec_op));
    assign amt      = CW'(io.operand_b[SW-1:0]);
    assign is_shift = dec_op inside {ALU_SLL, ALU_SRL, ALU_SRA};
    // Shift ops only reach the single-cycle path with a zero amount, so they pass operand_a through
    always_comb begin
        case (dec_op)
            ALU_AND:                   alu_res = io.operand_a & io.operand_b;
            ALU_OR:                    alu_res = io.operand_a | io.operand_b;
            ALU_ADD:                   alu_res = io.operand_a + io.operand_b;
            ALU_XOR:                   alu_res = io.operand_a ^ io.operand_b;
            ALU_SUB:                   alu_res = io.operand_a - io.operand_b;
            ALU_SLT:                   alu_res = XLEN'($signed(io.operand_a) < $signed(io.operand_b));
            ALU_SLTU:                  alu_res = XLEN'(io.operand_a < io.operand_b);
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = io.operand_a;
            default:                   alu_res = '0;
        endcase
    end
    assign sh_nxt = sh_op == ALU_SLL ? sh_val << step :
                    sh_op == ALU_SRA ? $unsigned($signed(sh_val) >>> step) : sh_val >> step;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state_q <= IDLE;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (flush) state_d = IDLE;
        else if (state_q == IDLE && acc && !ld_now) state_d = SHIFT;
        else if (sh_done) state_d = IDLE;
    end
    always_comb begin
        io.in_ready = state_q == IDLE && !flush && (!io.out_valid || io.out_ready);
        acc         = io.in_valid && io.in_ready;
        ld_now      = acc && !(is_shift && amt != '0);
        sh_done     = state_q == SHIFT && !flush && sh_rem <= STEP;
        step        = sh_rem < STEP ? sh_rem : STEP;
    end
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            io.out_valid <= 1'b0;
            io.result    <= '0;
            io.zero      <= 1'b0;
            io.illegal   <= 1'b0;
            io.operation <= '0;
            sh_val       <= '0;
            sh_rem       <= '0;
            sh_op        <= ALU_AND;
        end else begin
            if (flush) io.out_valid <= 1'b0;
            else if (ld_now || sh_done) io.out_valid <= 1'b1;
            else if (io.out_ready) io.out_valid <= 1'b0;
            if (ld_now) begin
                io.result    <= alu_res;
                io.zero      <= alu_res == '0;
                io.illegal   <= dec_op == ALU_ILLEGAL;
                io.operation <= OP_W'(dec_op);
            end else if (sh_done) begin
                io.result    <= sh_nxt;
                io.zero      <= sh_nxt == '0;
                io.illegal   <= 1'b0;
                io.operation <= OP_W'(sh_op);
            end
            if (acc) begin
                sh_val <= io.operand_a;
                sh_rem <= amt;
                sh_op  <= dec_op;
            end else if (flush) begin
                sh_rem <= '0;
            end else if (state_q == SHIFT) begin
                sh_val <= sh_nxt;
                sh_rem <= sh_rem - step;
            end
        end
endmodule
